// File: rtl/axi_chunker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_chunker
// Brief    : Splits AXI read/write address requests (FIXED/INCR/WRAP) into
//            chunk commands of at most 2^CHUNK beats that never cross a
//            chunk-aligned boundary. Fully registered command output.
// Options  : AXI_CHUNKER_PAGE_SPLIT_EN - also keep INCR chunks inside 4 KiB
//            pages and add the xerr_o page-crossing flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi_chunker #(
  parameter int ADDRS     = 32,
  parameter int REQID     = 4,
  parameter int AXI_WIDTH = 32,
  parameter int CHUNK     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               avalid_i,
  output logic               aready_o,
  input  logic [7:0]         alen_i,
  input  logic [1:0]         aburst_i,
  input  logic [REQID-1:0]   aid_i,
  input  logic [ADDRS-1:0]   aaddr_i,
  output logic               xvalid_o,
  input  logic               xready_i,
  output logic [ADDRS-1:0]   xaddr_o,
  output logic [REQID-1:0]   xid_o,
  output logic [CHUNK:0]     xlen_o,
  output logic               xseq_o,
  output logic               xlast_o
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
  ,
  output logic               xerr_o
`endif
);

  localparam int               c_bb    = AXI_WIDTH / 8;
  localparam int               c_lbb   = $clog2(c_bb);
  localparam int               c_cb    = 1 << CHUNK;
  localparam logic [ADDRS-1:0] c_cb_a  = ADDRS'(c_cb);
  localparam logic [ADDRS-1:0] c_cbm_a = ADDRS'(c_cb - 1);
  localparam logic [ADDRS-1:0] c_one   = ADDRS'(1);
  localparam logic [1:0]       c_fixed = 2'd0;
  localparam logic [1:0]       c_wrap  = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // nothing pending beyond the chunk on the outputs
    ST_BUSY = 1'b1    // more chunks of the current request follow
  } state_t;

  state_t           r_state;
  logic [1:0]       r_burst;
  logic [ADDRS-1:0] r_mask;   // WRAP window mask
  logic [ADDRS-1:0] r_rem;    // beats remaining, including the chunk on the outputs

  logic [ADDRS-1:0] w_cur_n;
  logic [ADDRS-1:0] w_step;
  logic [ADDRS-1:0] w_next_a;
  logic [ADDRS-1:0] w_next_r;
  logic [ADDRS-1:0] w_new_r;
  logic [ADDRS-1:0] w_new_m;
  logic [ADDRS-1:0] w_sel_a;
  logic [ADDRS-1:0] w_sel_r;
  logic [ADDRS-1:0] w_sel_m;
  logic [1:0]       w_sel_b;
  logic [ADDRS-1:0] w_n;
  logic [CHUNK:0]   w_len;
  logic             w_seq;
  logic             w_accept;

  // Beats in the chunk starting at address a with r beats left.
  function automatic logic [ADDRS-1:0] f_beats(
    input logic [ADDRS-1:0] a,
    input logic [ADDRS-1:0] r,
    input logic [ADDRS-1:0] m,
    input logic [1:0]       b
  );
    logic [ADDRS-1:0] n;
    logic [ADDRS-1:0] room;
    logic [ADDRS-1:0] lim;
    room = c_cb_a - ((a >> c_lbb) & c_cbm_a);
    n    = (r < room) ? r : room;
    lim  = '0;
    if (b == c_wrap) begin
      lim = ((m - (a & m)) >> c_lbb) + c_one;
      if (lim < n) n = lim;
    end
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
    else if (b != c_fixed) begin
      lim = (ADDRS'(4096) - (a & ADDRS'(4095))) >> c_lbb;
      if (lim < n) n = lim;
    end
`endif
    if (b == c_fixed) n = c_one;
    return n;
  endfunction

  // Accept only when the output register is free or its final chunk drains.
  assign aready_o = !reset && (r_state == ST_IDLE) && (!xvalid_o || xready_i);
  assign w_accept = avalid_i && aready_o;

  // Next-chunk address/remaining computation and chunk sizing.
  always_comb begin
    w_cur_n  = ADDRS'(xlen_o) + c_one;
    w_step   = w_cur_n << c_lbb;
    w_next_r = r_rem - w_cur_n;
    case (r_burst)
      c_fixed: w_next_a = xaddr_o;
      c_wrap:  w_next_a = (xaddr_o & ~r_mask) | ((xaddr_o + w_step) & r_mask);
      default: w_next_a = xaddr_o + w_step;
    endcase
    w_new_r = ADDRS'(alen_i) + c_one;
    w_new_m = (w_new_r << c_lbb) - c_one;
    w_sel_a = w_accept ? aaddr_i  : w_next_a;
    w_sel_r = w_accept ? w_new_r  : w_next_r;
    w_sel_m = w_accept ? w_new_m  : r_mask;
    w_sel_b = w_accept ? aburst_i : r_burst;
    w_n     = f_beats(w_sel_a, w_sel_r, w_sel_m, w_sel_b);
    w_len   = w_n[CHUNK:0] - {{CHUNK{1'b0}}, 1'b1};
    w_seq   = (w_sel_r != w_n);
  end

`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
  logic [ADDRS-1:0] w_end;
  logic             w_page_cross;
  // Flag INCR requests whose full span straddles a 4 KiB page.
  always_comb begin
    w_end        = aaddr_i + (w_new_r << c_lbb) - c_one;
    w_page_cross = (aburst_i != c_fixed) && (aburst_i != c_wrap) &&
                   (((aaddr_i ^ w_end) >> 12) != '0);
  end
`endif

  // Request latch, chunk sequencing and registered command outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_burst  <= 2'd0;
      r_mask   <= '0;
      r_rem    <= '0;
      xvalid_o <= 1'b0;
      xaddr_o  <= '0;
      xid_o    <= '0;
      xlen_o   <= '0;
      xseq_o   <= 1'b0;
      xlast_o  <= 1'b1;
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
      xerr_o   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_burst  <= aburst_i;
      r_mask   <= w_new_m;
      r_rem    <= w_new_r;
      xid_o    <= aid_i;
      xvalid_o <= 1'b1;
      xaddr_o  <= aaddr_i;
      xlen_o   <= w_len;
      xseq_o   <= w_seq;
      xlast_o  <= !w_seq;
      r_state  <= w_seq ? ST_BUSY : ST_IDLE;
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
      xerr_o   <= w_page_cross;
`endif
    end else if (xvalid_o && xready_i) begin
      if (xseq_o) begin
        r_rem   <= w_next_r;
        xaddr_o <= w_next_a;
        xlen_o  <= w_len;
        xseq_o  <= w_seq;
        xlast_o <= !w_seq;
        r_state <= w_seq ? ST_BUSY : ST_IDLE;
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
        xerr_o  <= 1'b0;
`endif
      end else begin
        xvalid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_chunker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_chunker
// Brief    : Self-checking bench for axi_chunker: directed scenarios plus
//            randomized requests against a beat-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_chunker;

  localparam int ADDRS     = 32;
  localparam int REQID     = 4;
  localparam int AXI_WIDTH = 32;
  localparam int CHUNK     = 2;
  localparam int BB        = AXI_WIDTH / 8;
  localparam int CB        = 1 << CHUNK;
  localparam int S         = CB * BB;

  logic             clock = 1'b0;
  logic             reset;
  logic             avalid_i;
  logic             aready_o;
  logic [7:0]       alen_i;
  logic [1:0]       aburst_i;
  logic [REQID-1:0] aid_i;
  logic [ADDRS-1:0] aaddr_i;
  logic             xvalid_o;
  logic             xready_i;
  logic [ADDRS-1:0] xaddr_o;
  logic [REQID-1:0] xid_o;
  logic [CHUNK:0]   xlen_o;
  logic             xseq_o;
  logic             xlast_o;
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
  logic             xerr_o;
`endif

  axi_chunker #(.ADDRS(ADDRS), .REQID(REQID), .AXI_WIDTH(AXI_WIDTH), .CHUNK(CHUNK)) dut (
    .clock(clock), .reset(reset),
    .avalid_i(avalid_i), .aready_o(aready_o), .alen_i(alen_i), .aburst_i(aburst_i),
    .aid_i(aid_i), .aaddr_i(aaddr_i),
    .xvalid_o(xvalid_o), .xready_i(xready_i), .xaddr_o(xaddr_o), .xid_o(xid_o),
    .xlen_o(xlen_o), .xseq_o(xseq_o), .xlast_o(xlast_o)
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
    , .xerr_o(xerr_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]    addr;
    logic [CHUNK:0] len;
    logic           last;
    logic [REQID-1:0] id;
    logic           err;
  } chunk_t;

  chunk_t exp_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;

  logic [31:0]      nx_addr;
  logic [7:0]       nx_len;
  logic [1:0]       nx_burst;
  logic [REQID-1:0] nx_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: enumerate every AXI beat address, then group beats
  // into chunks wherever a chunk would overfill, cross an S boundary or
  // jump (wrap point), or for FIXED bursts on every beat.
  task automatic build(input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [REQID-1:0] id);
    int          n;
    logic [31:0] wsz, base, a, st, prev;
    logic [31:0] starts[$];
    int          cnts[$];
    int          cnt;
    bit          newc, incr;
    chunk_t      e;
    n    = int'(len) + 1;
    wsz  = n * BB;
    base = addr & ~(wsz - 1);
    incr = (burst == 2'd1) || (burst == 2'd3);
    st = 0; prev = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      case (burst)
        2'd0:    a = addr;
        2'd2:    a = base + ((addr - base + i * BB) & (wsz - 1));
        default: a = addr + i * BB;
      endcase
      newc = (i == 0) || (burst == 2'd0) || (cnt == CB) ||
             ((a / S) != (st / S)) || (a != prev + BB);
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
      if (incr && ((a >> 12) != (st >> 12))) newc = 1;
`endif
      if (newc) begin
        if (i > 0) begin starts.push_back(st); cnts.push_back(cnt); end
        st = a; cnt = 1;
      end else begin
        cnt++;
      end
      prev = a;
    end
    starts.push_back(st); cnts.push_back(cnt);
    for (int k = 0; k < starts.size(); k++) begin
      e.addr = starts[k];
      e.len  = (CHUNK+1)'(cnts[k] - 1);
      e.last = (k == starts.size() - 1);
      e.id   = id;
      e.err  = (k == 0) && incr && ((addr >> 12) != ((addr + wsz - 1) >> 12));
      exp_q.push_back(e);
    end
  endtask

  // Present one request while the output is idle; accepted on the next edge.
  task automatic send(input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [REQID-1:0] id);
    build(addr, len, burst, id);
    avalid_i = 1; aaddr_i = addr; alen_i = len; aburst_i = burst; aid_i = id;
    xready_i = 0;
    #1;
    chk("aready_idle", aready_o, 1);
    @(posedge clock); #1;
    avalid_i = 0;
  endtask

  // Consume expected chunks; optionally chain the nx_* request onto the
  // final handshake and optionally stall for 5 cycles starting at stall_at.
  task automatic collect(input int rdy_pct, input bit chain, input int stall_at);
    int  cyc = 0;
    bit  rdy, is_last, chained;
    chained = 0;
    chk("first_valid", xvalid_o, 1);
    while (exp_q.size() != 0) begin
      if (cyc > 2000) begin
        chk("timeout", 0, 1);
        exp_q.delete();
        break;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) rdy = 0;
      xready_i = rdy;
      is_last  = exp_q[0].last;
      if (chain && is_last && rdy) begin
        avalid_i = 1; aaddr_i = nx_addr; alen_i = nx_len; aburst_i = nx_burst; aid_i = nx_id;
      end
      #1;
      chk("xvalid", xvalid_o, 1);
      chk("xaddr", xaddr_o, exp_q[0].addr);
      chk("xlen", xlen_o, exp_q[0].len);
      chk("xid", xid_o, exp_q[0].id);
      chk("xlast", xlast_o, exp_q[0].last);
      chk("xseq", xseq_o, !exp_q[0].last);
`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
      chk("xerr", xerr_o, exp_q[0].err);
`endif
      chk("aready_busy", aready_o, rdy && is_last);
      @(posedge clock);
      if (rdy) void'(exp_q.pop_front());
      if (chain && is_last && rdy) begin
        build(nx_addr, nx_len, nx_burst, nx_id);
        chained = 1;
      end
      #1;
      avalid_i = 0;
      cyc++;
      if (chained) break;
    end
    xready_i = 0;
    if (!chained) chk("drain_idle", xvalid_o, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    logic [7:0]  wl [4];
    wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

    // Reset state
    reset = 1; avalid_i = 0; xready_i = 0; alen_i = 0; aburst_i = 0; aid_i = 0; aaddr_i = 0;
    #2;
    chk("rst_xvalid", xvalid_o, 0);
    chk("rst_aready", aready_o, 0);
    chk("rst_xaddr", xaddr_o, 0);
    chk("rst_xid", xid_o, 0);
    chk("rst_xlen", xlen_o, 0);
    chk("rst_xseq", xseq_o, 0);
    chk("rst_xlast", xlast_o, 1);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(posedge clock); #1;

    // Directed plan requests, each chained back-to-back onto the previous one
    send(32'h100, 8'd7, 2'd1, 4'd1);
    nx_addr = 32'h108; nx_len = 8'd5; nx_burst = 2'd1; nx_id = 4'd2;
    collect(100, 1, -1);
    nx_addr = 32'h138; nx_len = 8'd7; nx_burst = 2'd2; nx_id = 4'd3;
    collect(100, 1, -1);
    nx_addr = 32'h40;  nx_len = 8'd2; nx_burst = 2'd0; nx_id = 4'd4;
    collect(100, 1, -1);
    collect(100, 0, -1);

    // Backpressure mid-burst, then a request queued at the last handshake
    send(32'h300, 8'd15, 2'd1, 4'd5);
    nx_addr = 32'h400; nx_len = 8'd0; nx_burst = 2'd3; nx_id = 4'd6;
    collect(100, 1, 1);
    collect(100, 0, -1);

    // Reset during the 2nd of 4 chunks
    send(32'h200, 8'd15, 2'd1, 4'd7);
    xready_i = 1;
    #1;
    chk("rst_pre_xaddr", xaddr_o, 32'h200);
    @(posedge clock); #1;
    xready_i = 0;
    chk("rst_pre_xaddr2", xaddr_o, 32'h210);
    reset = 1;
    #1;
    chk("rst_mid_xvalid", xvalid_o, 0);
    chk("rst_mid_aready", aready_o, 0);
    chk("rst_mid_xlast", xlast_o, 1);
    @(posedge clock); #1;
    reset = 0;
    exp_q.delete();
    @(posedge clock); #1;
    send(32'h500, 8'd9, 2'd1, 4'd8);
    collect(100, 0, -1);

`ifdef AXI_CHUNKER_PAGE_SPLIT_EN
    send(32'hFF8, 8'd3, 2'd1, 4'd9);
    collect(100, 0, -1);
`endif

    // Randomized requests with random backpressure
    for (int it = 0; it < 40; it++) begin
      rb = 2'($urandom_range(0, 3));
      ra = $urandom() & ~32'(BB - 1);
      if (it % 7 == 0) ra = 32'hFFFF_FF00 | (ra & 32'hFC);
      if (rb == 2'd2) rl = wl[$urandom_range(0, 3)];
      else if (it % 10 == 0) rl = 8'd255;
      else rl = 8'($urandom_range(0, 31));
      send(ra, rl, rb, REQID'($urandom_range(0, 15)));
      collect(70, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
